// File: rtl/seq_addsub_if.sv
// Operand/result bundle for the chunked sequential adder/subtractor.
//   master : issues start/a/b/cin/s_op, observes s/cout/ovf/busy/done
//   slave  : the arithmetic block itself
interface seq_addsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             s_op;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, cin, s_op,
        input  s, cout, ovf, busy, done
    );

    modport slave (
        input  start, a, b, cin, s_op,
        output s, cout, ovf, busy, done
    );
endinterface

// File: rtl/seq_addsub.sv
// Sequential adder/subtractor that processes CHUNK bits per clock, LSB first.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_addsub_if.slave -- start/a/b/cin/s_op in; s/cout/ovf/busy/done out
// Subtraction is a - b computed as a + ~b + !cin, so cout=1 means no borrow.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands captured on the start edge
// RUN   | one chunk added per cycle; busy=1
// DONE  | one-cycle done pulse; s/cout/ovf were loaded entering this state
module seq_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_addsub_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("seq_addsub: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    idx_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q, ovf_q;

    logic [CHUNK-1:0] a_chunk, b_chunk, chunk_s;
    logic             last_chunk;
    logic             c_into_msb;

    assign last_chunk = (idx_q == CW'(NCH - 1));

    always_comb begin
        a_chunk = a_q[idx_q*CHUNK +: CHUNK];
        b_chunk = b_q[idx_q*CHUNK +: CHUNK];
        {carry_d, chunk_s} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the top bit recovered from its sum bit; only meaningful on the last chunk.
        c_into_msb = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_s[CHUNK-1];
        sum_d = sum_q;
        sum_d[idx_q*CHUNK +: CHUNK] = chunk_s;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_chunk) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.s_op ? ~bus.b : bus.b;
                        carry_q <= bus.s_op ? ~bus.cin : bus.cin;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    if (last_chunk) begin
                        // Partial sums live only in sum_q; s changes once per operation.
                        s_q    <= sum_d;
                        cout_q <= carry_d;
                        ovf_q  <= c_into_msb ^ carry_d;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_seq_addsub.sv
module tb_seq_addsub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_addsub_if #(.WIDTH(16)) bus16 ();
    seq_addsub_if #(.WIDTH(8))  bus8 ();

    seq_addsub #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    seq_addsub #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          cyc;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitors: compare on every done pulse, and check s is stable while busy.
    int          bcnt16 = 0, bcnt8 = 0;
    logic [15:0] last16 = '0;
    logic [7:0]  last8 = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            bcnt16 = 0;
            last16 = '0;
        end else begin
            if (bus16.busy) begin
                bcnt16++;
                chk("s16_hold_while_busy", 32'(bus16.s), 32'(last16));
            end
            if (bus16.done) begin
                if (q16.size() == 0) begin
                    chk("spurious_done16", 32'(bus16.done), 32'd0);
                end else begin
                    e = q16.pop_front();
                    chk("s16", 32'(bus16.s), 32'(e.s));
                    chk("cout16", 32'(bus16.cout), 32'(e.c));
                    chk("ovf16", 32'(bus16.ovf), 32'(e.o));
                    chk("done16_cycle", 32'(cyc), 32'(e.cyc));
                    chk("busy16_cycles", 32'(bcnt16), 32'd4);
                    last16 = e.s;
                end
                bcnt16 = 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            bcnt8 = 0;
            last8 = '0;
        end else begin
            if (bus8.busy) begin
                bcnt8++;
                chk("s8_hold_while_busy", 32'(bus8.s), 32'(last8));
            end
            if (bus8.done) begin
                if (q8.size() == 0) begin
                    chk("spurious_done8", 32'(bus8.done), 32'd0);
                end else begin
                    e = q8.pop_front();
                    chk("s8", 32'(bus8.s), 32'(e.s[7:0]));
                    chk("cout8", 32'(bus8.cout), 32'(e.c));
                    chk("ovf8", 32'(bus8.ovf), 32'(e.o));
                    chk("done8_cycle", 32'(cyc), 32'(e.cyc));
                    chk("busy8_cycles", 32'(bcnt8), 32'd1);
                    last8 = e.s[7:0];
                end
                bcnt8 = 0;
            end
        end
    end

    // Start is sampled at the next posedge (edge k = cyc+1); done expected NCH edges later.
    task automatic issue16(input logic op, input logic [15:0] av, input logic [15:0] bv,
                           input logic ci, input logic [15:0] es, input logic ec, input logic eo);
        exp_t e;
        @(negedge clk);
        bus16.start = 1'b1;
        bus16.a     = av;
        bus16.b     = bv;
        bus16.cin   = ci;
        bus16.s_op  = op;
        e.s = es; e.c = ec; e.o = eo; e.cyc = cyc + 1 + 4;
        q16.push_back(e);
        @(negedge clk);
        bus16.start = 1'b0;
    endtask

    task automatic issue8(input logic op, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = av;
        bus8.b     = bv;
        bus8.cin   = ci;
        bus8.s_op  = op;
        e.s = {8'h00, es}; e.c = ec; e.o = eo; e.cyc = cyc + 1 + 1;
        q8.push_back(e);
        @(negedge clk);
        bus8.start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q16.size() != 0 || q8.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    task automatic chk_all_zero16(input string tag);
        chk({tag, "_s"},    32'(bus16.s),    32'd0);
        chk({tag, "_cout"}, 32'(bus16.cout), 32'd0);
        chk({tag, "_ovf"},  32'(bus16.ovf),  32'd0);
        chk({tag, "_busy"}, 32'(bus16.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus16.done), 32'd0);
    endtask

    initial begin
        bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.s_op = 1'b0;
        bus8.start  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0; bus8.s_op  = 1'b0;

        repeat (3) @(negedge clk);
        chk_all_zero16("reset16");
        chk("reset8_s", 32'(bus8.s), 32'd0);
        chk("reset8_busy", 32'(bus8.busy), 32'd0);
        chk("reset8_done", 32'(bus8.done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // op, a, b, cin -> s, cout, ovf
        issue16(1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0); drain();
        issue16(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0); drain();
        issue16(1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1); drain();
        issue16(1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0); drain();
        issue16(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1); drain();
        issue16(1'b1, 16'h0010, 16'h0001, 1'b1, 16'h000E, 1'b1, 1'b0); drain();
        issue16(1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0); drain();
        issue16(1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1); drain();

        // Restart and operand changes during RUN must be ignored.
        issue16(1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
        bus16.start = 1'b1; bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.s_op = 1'b1; bus16.cin = 1'b1;
        @(negedge clk);
        bus16.start = 1'b0;
        drain();
        chk("s16_held_after_done", 32'(bus16.s), 32'h3333);

        // Reset during the second RUN cycle aborts without a done pulse.
        issue16(1'b0, 16'h00F0, 16'h0F0F, 1'b0, 16'h0FFF, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q16.delete();
        #1;
        chk_all_zero16("abort16");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort16_no_restart_busy", 32'(bus16.busy), 32'd0);
        issue16(1'b0, 16'h0F0F, 16'h00F0, 1'b1, 16'h1000, 1'b0, 1'b0); drain();

        // Single-chunk configuration.
        issue8(1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0); drain();
        issue8(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1); drain();
        issue8(1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0); drain();
        issue8(1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0); drain();

        chk("q16_drained", 32'(q16.size()), 32'd0);
        chk("q8_drained", 32'(q8.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
